// File: rtl/deserializer_if.sv
// Output word stream of the deserializer.
//   data  : word at the FIFO head (27 bits)
//   valid : a word is available
//   ready : consumer accepts data when valid && ready on a clock edge
// master = producer (deserializer), slave = consumer.
interface deserializer_if;
   logic [26:0] data;
   logic        valid;
   logic        ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/deserializer.sv
// Serial-to-parallel receiver for 27-bit MSB-first frames with an output FIFO.
// A frame starts when frame_start is high; that cycle's ser_in is bit 26.
// Completed words go into a FIFO drained through the word_bus handshake.
// The block also tracks aborted frames, test-pattern mismatches and dropped words.
//
// Ports:
//   clk_out         serial bit clock, all registers on its rising edge
//   rst_n           asynchronous active-low reset
//   ser_in          serial data, MSB first
//   frame_start     marks bit 26 of a frame
//   check_pattern   compare each completed word against 27'h4AACC0F
//   clear_cnt       synchronous clear of abort_cnt, pattern_err_cnt, overflow
//   word_bus        data/valid/ready output stream (master side)
//   fifo_count      number of words held
//   overflow        sticky: a completed word was dropped
//   abort_cnt       saturating count of aborted frames
//   pattern_err_cnt saturating count of pattern mismatches
//
// state | meaning
// IDLE  | waiting for frame_start
// SHIFT | receiving bits 25..0 of the current frame
module deserializer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk_out,
   input  logic                          rst_n,
   input  logic                          ser_in,
   input  logic                          frame_start,
   input  logic                          check_pattern,
   input  logic                          clear_cnt,
   deserializer_if.master                word_bus,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   output logic [7:0]                    abort_cnt,
   output logic [7:0]                    pattern_err_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [26:0]   TEST_PATTERN = 27'h4AACC0F;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state;
   logic [4:0]    bit_cnt;
   logic [26:0]   shreg;

   logic [26:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic [26:0]   word_next;
   logic          word_done;
   logic          aborting;
   logic          not_empty;
   logic          full;
   logic          pop;
   logic          wr_en;
   logic          pattern_bad;

   assign word_next   = {shreg[25:0], ser_in};
   // frame_start wins over completion, even on the 27th bit
   assign word_done   = (state == SHIFT) && !frame_start && (bit_cnt == 5'd26);
   assign aborting    = (state == SHIFT) && frame_start;
   assign not_empty   = (count != '0);
   assign full        = (count == FULL_CNT);
   assign pop         = not_empty && word_bus.ready;
   // a simultaneous pop frees the slot the push needs
   assign wr_en       = word_done && (!full || pop);
   assign pattern_bad = word_done && check_pattern && (word_next != TEST_PATTERN);

   assign word_bus.valid = not_empty;
   assign word_bus.data  = not_empty ? mem[rd_ptr] : '0;
   assign fifo_count     = count;

   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         bit_cnt <= '0;
         shreg   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (frame_start) begin
                  shreg   <= {26'd0, ser_in};
                  bit_cnt <= 5'd1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (frame_start) begin
                  shreg   <= {26'd0, ser_in};
                  bit_cnt <= 5'd1;
               end else if (bit_cnt == 5'd26) begin
                  shreg   <= word_next;
                  bit_cnt <= '0;
                  state   <= IDLE;
               end else begin
                  shreg   <= word_next;
                  bit_cnt <= bit_cnt + 5'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_out) begin
      if (wr_en) mem[wr_ptr] <= word_next;
   end

   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         overflow        <= 1'b0;
         abort_cnt       <= '0;
         pattern_err_cnt <= '0;
      end else if (clear_cnt) begin
         overflow        <= 1'b0;
         abort_cnt       <= '0;
         pattern_err_cnt <= '0;
      end else begin
         if (word_done && !wr_en) overflow <= 1'b1;
         if (aborting && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
         if (pattern_bad && pattern_err_cnt != 8'hFF)
            pattern_err_cnt <= pattern_err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;

   localparam int DEPTH = 4;
   localparam logic [26:0] PAT = 27'h4AACC0F;

   logic       clk_out = 1'b0;
   logic       rst_n = 1'b0;
   logic       ser_in = 1'b0;
   logic       frame_start = 1'b0;
   logic       check_pattern = 1'b0;
   logic       clear_cnt = 1'b0;
   logic       data_ready = 1'b0;
   logic [2:0] fifo_count;
   logic       overflow;
   logic [7:0] abort_cnt;
   logic [7:0] pattern_err_cnt;
   logic [26:0] data_out;
   logic       data_valid;

   int checks = 0;
   int failures = 0;

   deserializer_if bus ();
   assign bus.ready  = data_ready;
   assign data_out   = bus.data;
   assign data_valid = bus.valid;

   deserializer #(.FIFO_DEPTH(DEPTH)) dut (
      .clk_out         (clk_out),
      .rst_n           (rst_n),
      .ser_in          (ser_in),
      .frame_start     (frame_start),
      .check_pattern   (check_pattern),
      .clear_cnt       (clear_cnt),
      .word_bus        (bus.master),
      .fifo_count      (fifo_count),
      .overflow        (overflow),
      .abort_cnt       (abort_cnt),
      .pattern_err_cnt (pattern_err_cnt)
   );

   always #5 clk_out = ~clk_out;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame assembly from the bit stream, FIFO occupancy and
   // the status counters, worked out from the inputs alone.
   logic [26:0] exp_q[$];
   int  m_occ, m_nb, m_acc, m_abort, m_perr;
   bit  m_in_frame, m_ovf, m_done, m_pop, m_abort_inc, m_perr_inc, m_ovf_set;
   logic [26:0] m_word;

   always @(posedge clk_out or negedge rst_n) begin
      if (!rst_n) begin
         m_in_frame = 0; m_nb = 0; m_acc = 0; m_occ = 0;
         m_ovf = 0; m_abort = 0; m_perr = 0;
         exp_q.delete();
      end else begin
         m_done = 0; m_abort_inc = 0; m_perr_inc = 0; m_ovf_set = 0;
         m_pop = (m_occ > 0) && data_ready;
         if (frame_start) begin
            if (m_in_frame) m_abort_inc = 1;
            m_in_frame = 1; m_nb = 1; m_acc = int'(ser_in);
         end else if (m_in_frame) begin
            m_acc = m_acc * 2 + int'(ser_in);
            m_nb++;
            if (m_nb == 27) begin
               m_done = 1; m_word = m_acc[26:0]; m_in_frame = 0;
            end
         end
         if (m_pop) m_occ--;
         if (m_done) begin
            if (m_occ < DEPTH) begin
               m_occ++;
               exp_q.push_back(m_word);
            end else m_ovf_set = 1;
            if (check_pattern && m_word != PAT) m_perr_inc = 1;
         end
         if (clear_cnt) begin
            m_ovf = 0; m_abort = 0; m_perr = 0;
         end else begin
            if (m_ovf_set) m_ovf = 1;
            if (m_abort_inc) m_abort = (m_abort < 255) ? m_abort + 1 : 255;
            if (m_perr_inc) m_perr = (m_perr < 255) ? m_perr + 1 : 255;
         end
      end
   end

   // Monitor: compares status every cycle and pops the scoreboard on each handshake.
   always @(negedge clk_out) begin
      check("valid", data_valid, longint'(m_occ != 0));
      check("fifo_count", fifo_count, m_occ);
      check("overflow", overflow, m_ovf);
      check("abort_cnt", abort_cnt, m_abort);
      check("pattern_err_cnt", pattern_err_cnt, m_perr);
      if (rst_n && data_valid && data_ready) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL data: got %0h with no word expected at %0t", data_out, $time);
         end else begin
            check("data", data_out, exp_q[0]);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk_out);
      #2;
   endtask

   task automatic send_frame(input logic [26:0] w, input int nbits = 27, input bit ready_last = 0);
      for (int i = 0; i < nbits; i++) begin
         frame_start = (i == 0);
         ser_in = w[26-i];
         if (ready_last && i == 26) data_ready = 1'b1;
         tick();
      end
      frame_start = 1'b0;
      ser_in = 1'($urandom);
      if (ready_last) data_ready = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_cnt = 1'b1;
      tick();
      clear_cnt = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      data_ready = 1'b1;
      while ((exp_q.size() != 0 || data_valid) && n < 200) begin
         tick();
         n++;
      end
      check("drain_timeout", longint'(n < 200), 1);
   endtask

   initial begin
      #1;
      check("rst_valid", data_valid, 0);
      check("rst_count", fifo_count, 0);
      check("rst_data", data_out, 0);
      check("rst_overflow", overflow, 0);
      check("rst_abort", abort_cnt, 0);
      check("rst_perr", pattern_err_cnt, 0);
      tick(); tick();
      rst_n = 1'b1;

      // single frame carrying the test pattern
      check_pattern = 1'b1;
      send_frame(PAT);
      check("single_valid", data_valid, 1);
      check("single_data", data_out, PAT);
      check("single_perr", pattern_err_cnt, 0);
      drain();

      // back-pressure: five frames into a four-deep FIFO
      data_ready = 1'b0;
      check_pattern = 1'b0;
      for (int f = 0; f < 5; f++) send_frame(27'($urandom));
      check("bp_count", fifo_count, 4);
      check("bp_overflow", overflow, 1);
      drain();
      check("bp_empty", data_valid, 0);
      pulse_clear();
      check("clear_overflow", overflow, 0);

      // abort at E10, restarted frame completes at E36
      send_frame(27'h1234567, 10);
      send_frame(27'h7654321);
      check("abort_cnt", abort_cnt, 1);
      check("abort_one_word", fifo_count, 1);
      drain();

      // pattern mismatch counting and saturation
      pulse_clear();
      check_pattern = 1'b1;
      send_frame(27'h0000001);
      check("perr_one", pattern_err_cnt, 1);
      for (int f = 0; f < 300; f++) send_frame(27'($urandom) | 27'h1000000 ^ 27'h0);
      check("perr_sat", pattern_err_cnt, 255);
      pulse_clear();
      check("perr_clear", pattern_err_cnt, 0);
      check_pattern = 1'b0;
      drain();

      // full FIFO with a pop on the push edge
      data_ready = 1'b0;
      for (int f = 0; f < 4; f++) send_frame(27'($urandom));
      check("full_count", fifo_count, 4);
      send_frame(27'h5A5A5A5, 27, 1);
      check("full_pop_count", fifo_count, 4);
      check("full_pop_overflow", overflow, 0);
      drain();

      // reset in the middle of a frame
      data_ready = 1'b0;
      send_frame(27'h3333333);
      send_frame(27'h2222222, 12);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", data_valid, 0);
      check("mid_rst_count", fifo_count, 0);
      check("mid_rst_data", data_out, 0);
      check("mid_rst_abort", abort_cnt, 0);
      tick();
      rst_n = 1'b1;
      send_frame(27'h6ABCDEF);
      check("post_rst_data", data_out, 27'h6ABCDEF);
      check("post_rst_abort", abort_cnt, 0);
      drain();

      // randomized traffic
      for (int f = 0; f < 60; f++) begin
         data_ready = 1'($urandom);
         check_pattern = 1'($urandom);
         clear_cnt = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 4) == 0) send_frame(27'($urandom), $urandom_range(1, 26));
         else send_frame(($urandom_range(0, 2) == 0) ? PAT : 27'($urandom));
         clear_cnt = 1'b0;
         for (int k = $urandom_range(0, 3); k > 0; k--) begin
            data_ready = 1'($urandom);
            tick();
         end
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 Parameter FIFO_DEPTH, default 4: number of 27-bit word entries in the output FIFO (power of two, 2..16).
REQ-003 ClkOut  in  1  serial bit clock; every register is clocked on its rising edge.
REQ-004 RstN  in  1  asynchronous active-low reset.
REQ-005 SerIn  in  1  serial data, MSB first, one bit per ClkOut cycle.
REQ-006 FrameStart  in  1  high in the cycle in which SerIn carries bit 26 of a frame.
REQ-007 CheckPattern  in  1  when high, every completed word is compared with the test pattern 27'h4AACC0F.
REQ-008 ClearCnt  in  1  synchronous clear of AbortCnt, PatternErrCnt and Overflow.
REQ-009 DataReady  in  1  consumer accepts DataOut when DataReady and DataValid are both high.
REQ-010 DataOut  out  27  word at the FIFO head.
REQ-011 DataValid  out  1  FIFO not empty.
REQ-012 FifoCount  out  clog2(FIFO_DEPTH)+1  number of words held.
REQ-013 Overflow  out  1  sticky: a completed word was dropped.
REQ-014 AbortCnt  out  8  saturating count of aborted frames.
REQ-015 PatternErrCnt  out  8  saturating count of pattern mismatches.

Function
REQ-016 FSM states: IDLE (waiting for a frame) and SHIFT (receiving bits 25..0).
REQ-017 IDLE: on an edge with FrameStart=1, SerIn SHALL be loaded as bit 26, the bit counter set to 1, and the state changed to SHIFT. With FrameStart=0, SerIn is ignored.
REQ-018 SHIFT: on each edge, SerIn SHALL be shifted in and the counter incremented. On the edge that samples the 27th bit (counter==26), the assembled word SHALL be pushed into the FIFO and the state SHALL return to IDLE.
REQ-019 Latency: if FrameStart is sampled at edge E0, the word is written at edge E26. If the FIFO was empty, DataValid=1 and DataOut=word from E26 onward.
REQ-020 FrameStart=1 at any edge while in SHIFT, including counter==26, SHALL discard the partial word. On that edge it SHALL increment AbortCnt, load SerIn as the new bit 26, and set the counter to 1. No word is pushed.
REQ-021 FIFO pop occurs on an edge with DataValid=1 and DataReady=1. Order SHALL be first-in first-out. DataOut holds its value while DataReady=0.
REQ-022 Push when full with a simultaneous pop SHALL succeed, with no overflow and FifoCount unchanged.
REQ-023 Push when full without a pop SHALL drop the new word, set Overflow, and leave the FIFO contents unchanged.
REQ-024 A pop when empty SHALL have no effect. Push and pop on the same edge when empty SHALL only push.
REQ-025 When CheckPattern=1, PatternErrCnt SHALL increment on each completed word that is not equal to 27'h4AACC0F. The compare SHALL use the assembled word, whether or not it was dropped by overflow.
REQ-026 Counters SHALL saturate at 255 with no wrap. Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-027 ClearCnt has priority over an increment on the same edge: the counters go to 0 and Overflow goes to 0. ClearCnt does not affect the FSM or the FIFO.

Reset
REQ-028 RstN=0 SHALL immediately force the following:
- state IDLE, counter 0, shift register 0;
- FIFO empty: DataValid=0, FifoCount=0, DataOut=0;
- Overflow=0, AbortCnt=0, PatternErrCnt=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial word without counting an abort.
REQ-030 After RstN deasserts, the first edge SHALL accept FrameStart.

Verification
REQ-031 Single frame: FrameStart at E0 with serial 27'h4AACC0F and CheckPattern=1 -> DataValid rises after E26, DataOut=27'h4AACC0F, PatternErrCnt=0.
REQ-032 Back-pressure: DataReady=0 and 5 frames with FIFO_DEPTH=4 -> FifoCount=4, Overflow=1. Then DataReady=1 -> frames 1-4 emerge in order, and frame 5 is absent.
REQ-033 Abort: FrameStart at E0 and again at E10 -> AbortCnt=1, and exactly one word completes at E36.
REQ-034 Pattern error: CheckPattern=1 and word 27'h0000001 -> PatternErrCnt=1. Then 300 bad words -> 255. Then ClearCnt -> 0.
REQ-035 Full with simultaneous pop: FIFO full, DataReady=1 on the push edge -> FifoCount stays 4 and Overflow stays 0.
REQ-036 Reset mid-frame: RstN=0 at E12 -> all outputs 0 and AbortCnt=0. Next frame received intact.
